// File: rtl/qsfp_mgmt.sv
// qsfp_mgmt: per-cage presence/interrupt debounce, reset/init sequencing and
// an exclusive I2C modsel handshake across PORTS QSFP cages.
module qsfp_mgmt #(
  parameter int PORTS        = 2,
  parameter int DEBOUNCE     = 1024,
  parameter int RESET_CYCLES = 2000,
  parameter int INIT_CYCLES  = 4000,
  parameter int SEL_SETUP    = 4,
  localparam int SW = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic [PORTS-1:0] qsfp_modprsl_i,
  input  logic [PORTS-1:0] qsfp_intl_i,
  output logic [PORTS-1:0] qsfp_resetl_o,
  output logic [PORTS-1:0] qsfp_lpmode_o,
  output logic [PORTS-1:0] qsfp_modsell_o,
  input  logic [PORTS-1:0] soft_reset_i,
  input  logic [PORTS-1:0] lpmode_req_i,
  input  logic             sel_req_i,
  input  logic [SW-1:0]    sel_port_i,
  output logic             sel_gnt_o,
  output logic             sel_err_o,
  output logic [PORTS-1:0] port_ready_o,
  output logic [PORTS-1:0] port_int_o,
  output logic [PORTS-1:0] present_chg_o
);
  localparam int N  = 2 * PORTS;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int CW = $clog2(((RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES) + 1);
  localparam int TW = $clog2(SEL_SETUP + 1);

  typedef enum logic [1:0] {ABSENT, RESET, INIT, READY} port_st_e;
  typedef enum logic [1:0] {IDLE, SETUP, GRANT, ERR} sel_st_e;

  // Low half of the pin vectors is modprsl, high half is intl.
  logic [N-1:0]     sync1_q, sync2_q, deb_q, deb_d;
  logic [DW-1:0]    dcnt_q [N];
  logic [DW-1:0]    dcnt_d [N];
  logic [PORTS-1:0] prs_prev_q, chg_q, present, ready;
  port_st_e         pst_q [PORTS];
  port_st_e         pst_d [PORTS];
  logic [CW-1:0]    pcnt_q [PORTS];
  logic [CW-1:0]    pcnt_d [PORTS];
  sel_st_e          sst_q, sst_d;
  logic [SW-1:0]    sidx_q, sidx_d;
  logic [TW-1:0]    scnt_q, scnt_d;
  logic             serr_q, serr_d;

  assign present = ~deb_q[PORTS-1:0];

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      prs_prev_q <= '1;
      chg_q      <= '0;
      for (int i = 0; i < N; i++) dcnt_q[i] <= '0;
      for (int i = 0; i < PORTS; i++) begin
        pst_q[i]  <= ABSENT;
        pcnt_q[i] <= '0;
      end
      sst_q  <= IDLE;
      sidx_q <= '0;
      scnt_q <= '0;
      serr_q <= 1'b0;
    end else begin
      sync1_q    <= {qsfp_intl_i, qsfp_modprsl_i};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      dcnt_q     <= dcnt_d;
      prs_prev_q <= deb_q[PORTS-1:0];
      chg_q      <= deb_q[PORTS-1:0] ^ prs_prev_q;
      pst_q      <= pst_d;
      pcnt_q     <= pcnt_d;
      sst_q      <= sst_d;
      sidx_q     <= sidx_d;
      scnt_q     <= scnt_d;
      serr_q     <= serr_d;
    end
  end

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE - 1)) deb_d[i] = sync2_q[i];
        else dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
    end
  end

  // Removal outranks everything; soft reset only matters once a module is in sequence.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      pst_d[i]  = pst_q[i];
      pcnt_d[i] = '0;
      if (!present[i]) pst_d[i] = ABSENT;
      else if (pst_q[i] == ABSENT || soft_reset_i[i]) pst_d[i] = RESET;
      else if (pst_q[i] == RESET) begin
        if (pcnt_q[i] == CW'(RESET_CYCLES - 1)) pst_d[i] = INIT;
        else pcnt_d[i] = pcnt_q[i] + CW'(1);
      end else if (pst_q[i] == INIT) begin
        if (pcnt_q[i] == CW'(INIT_CYCLES - 1)) pst_d[i] = READY;
        else pcnt_d[i] = pcnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    sst_d  = sst_q;
    sidx_d = sidx_q;
    scnt_d = '0;
    serr_d = 1'b0;
    case (sst_q)
      IDLE: if (sel_req_i) begin
        if (int'(sel_port_i) < PORTS && ready[sel_port_i]) begin
          sst_d  = SETUP;
          sidx_d = sel_port_i;
        end else begin
          sst_d  = ERR;
          serr_d = 1'b1;
        end
      end
      SETUP: if (!ready[sidx_q]) begin
        sst_d  = ERR;
        serr_d = 1'b1;
      end else if (!sel_req_i) sst_d = IDLE;
      else if (scnt_q == TW'(SEL_SETUP - 1)) sst_d = GRANT;
      else scnt_d = scnt_q + TW'(1);
      GRANT: if (!ready[sidx_q]) begin
        sst_d  = ERR;
        serr_d = 1'b1;
      end else if (!sel_req_i) sst_d = IDLE;
      default: if (!sel_req_i) sst_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      ready[i]          = pst_q[i] == READY;
      qsfp_resetl_o[i]  = pst_q[i] == INIT || pst_q[i] == READY;
      qsfp_lpmode_o[i]  = ready[i] ? lpmode_req_i[i] : 1'b1;
      qsfp_modsell_o[i] = !((sst_q == SETUP || sst_q == GRANT) && sidx_q == SW'(i));
    end
  end

  assign port_ready_o  = ready;
  assign port_int_o    = ready & ~deb_q[N-1:PORTS];
  assign present_chg_o = chg_q;
  assign sel_gnt_o     = sst_q == GRANT;
  assign sel_err_o     = serr_q;
endmodule

// File: tb/tb_qsfp_mgmt.sv
// tb_qsfp_mgmt: randomized pin/request stimulus checked every cycle against a
// timestamp-based reference model of debounce, port sequencing and selection.
module tb_qsfp_mgmt;
  localparam int P = 2, D = 4, RC = 8, IC = 16, SS = 2;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [P-1:0] modprsl = '0, intl = '1, soft_reset = '0, lpmode_req = '0;
  logic         sel_req = 1'b0;
  logic [0:0]   sel_port = '0;
  logic [P-1:0] resetl, lpmode, modsell, port_ready, port_int, present_chg;
  logic         sel_gnt, sel_err;

  qsfp_mgmt #(.PORTS(P), .DEBOUNCE(D), .RESET_CYCLES(RC), .INIT_CYCLES(IC), .SEL_SETUP(SS)) dut (
    .clock_i(clk), .resetn_i(rst_n),
    .qsfp_modprsl_i(modprsl), .qsfp_intl_i(intl),
    .qsfp_resetl_o(resetl), .qsfp_lpmode_o(lpmode), .qsfp_modsell_o(modsell),
    .soft_reset_i(soft_reset), .lpmode_req_i(lpmode_req),
    .sel_req_i(sel_req), .sel_port_i(sel_port),
    .sel_gnt_o(sel_gnt), .sel_err_o(sel_err),
    .port_ready_o(port_ready), .port_int_o(port_int), .present_chg_o(present_chg)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pin's debounced value is whatever its last D synchronised
  // samples agree on; a port's phase is the time elapsed since its sequence began.
  logic [2*P-1:0] deb_m, deb_prev;
  logic           hist [2*P][$];
  logic [P-1:0]   chg_m;
  int             start_m [P];
  int             cyc, sp, tsel;
  bit             busy, waitrel, errp;

  function automatic bit ready_at(int i, int n);
    return start_m[i] >= 0 && n - start_m[i] >= RC + IC;
  endfunction

  task automatic model_reset();
    deb_m = '1; deb_prev = '1; chg_m = '0;
    busy = 0; waitrel = 0; errp = 0; cyc = 0; sp = 0; tsel = 0;
    for (int b = 0; b < 2*P; b++) begin
      hist[b].delete();
      repeat (D + 2) hist[b].push_back(1'b1);
    end
    for (int i = 0; i < P; i++) start_m[i] = -1;
  endtask

  task automatic model_step();
    logic [P-1:0]   rdy_old;
    logic [2*P-1:0] pins, old;
    bit             same;
    pins = {intl, modprsl};
    for (int i = 0; i < P; i++) rdy_old[i] = ready_at(i, cyc);
    old = deb_m;
    cyc++;
    errp = 0;
    if (busy) begin
      if (!rdy_old[sp]) begin busy = 0; errp = 1; waitrel = 1; end
      else if (!sel_req) busy = 0;
    end else if (waitrel) begin
      if (!sel_req) waitrel = 0;
    end else if (sel_req) begin
      if (int'(sel_port) < P && rdy_old[sel_port]) begin busy = 1; sp = int'(sel_port); tsel = cyc; end
      else begin errp = 1; waitrel = 1; end
    end
    for (int i = 0; i < P; i++)
      if (old[i]) start_m[i] = -1;
      else if (start_m[i] < 0 || soft_reset[i]) start_m[i] = cyc;
    for (int b = 0; b < 2*P; b++) begin
      hist[b].push_back(pins[b]);
      void'(hist[b].pop_front());
      same = 1;
      for (int k = 1; k < D; k++) if (hist[b][k] != hist[b][0]) same = 0;
      if (same) deb_m[b] = hist[b][0];
    end
    chg_m = old[P-1:0] ^ deb_prev[P-1:0];
    deb_prev = old;
  endtask

  task automatic check_all();
    logic [P-1:0] e_rl, e_lp, e_rdy, e_int, e_ms;
    bit r;
    e_ms = '1;
    if (busy) e_ms[sp] = 1'b0;
    for (int i = 0; i < P; i++) begin
      r = ready_at(i, cyc);
      e_rdy[i] = r;
      e_rl[i]  = start_m[i] >= 0 && cyc - start_m[i] >= RC;
      e_lp[i]  = r ? lpmode_req[i] : 1'b1;
      e_int[i] = r & ~deb_m[P+i];
    end
    check("resetl", 32'(resetl), 32'(e_rl));
    check("lpmode", 32'(lpmode), 32'(e_lp));
    check("port_ready", 32'(port_ready), 32'(e_rdy));
    check("port_int", 32'(port_int), 32'(e_int));
    check("present_chg", 32'(present_chg), 32'(chg_m));
    check("modsell", 32'(modsell), 32'(e_ms));
    check("sel_gnt", 32'(sel_gnt), 32'(busy && cyc - tsel >= SS));
    check("sel_err", 32'(sel_err), 32'(errp));
  endtask

  task automatic check_reset(input string p);
    check({p, "_resetl"}, 32'(resetl), 32'(0));
    check({p, "_lpmode"}, 32'(lpmode), 32'(2'b11));
    check({p, "_modsell"}, 32'(modsell), 32'(2'b11));
    check({p, "_sel_gnt"}, 32'(sel_gnt), 32'(0));
    check({p, "_sel_err"}, 32'(sel_err), 32'(0));
    check({p, "_port_ready"}, 32'(port_ready), 32'(0));
    check({p, "_port_int"}, 32'(port_int), 32'(0));
    check({p, "_present_chg"}, 32'(present_chg), 32'(0));
  endtask

  // Stable base levels with occasional short glitches, some long enough to pass debounce.
  logic [P-1:0] prs_base = '0, int_base = '1;
  int pg [P];
  int ig [P];

  task automatic drive_random();
    for (int i = 0; i < P; i++) begin
      if ($urandom_range(249) == 0) prs_base[i] = ~prs_base[i];
      if ($urandom_range(39) == 0) int_base[i] = ~int_base[i];
      if (pg[i] == 0 && $urandom_range(99) == 0) pg[i] = $urandom_range(6, 1);
      if (ig[i] == 0 && $urandom_range(49) == 0) ig[i] = $urandom_range(6, 1);
      modprsl[i] = prs_base[i] ^ (pg[i] > 0);
      intl[i]    = int_base[i] ^ (ig[i] > 0);
      if (pg[i] > 0) pg[i]--;
      if (ig[i] > 0) ig[i]--;
      soft_reset[i] = $urandom_range(199) == 0;
      if ($urandom_range(9) == 0) lpmode_req[i] = ~lpmode_req[i];
    end
    if ($urandom_range(7) == 0) sel_req = ~sel_req;
    sel_port = 1'($urandom_range(1));
  endtask

  initial begin
    for (int i = 0; i < P; i++) begin pg[i] = 0; ig[i] = 0; end
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (3) @(negedge clk);
    check_reset("por_hold");
    rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
      if (c == 2000) begin
        rst_n = 1'b0;
        #1 check_reset("mid");
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("mid_hold");
        rst_n = 1'b1;
      end
      drive_random();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qsfp_mgmt.md
QSFP_MGMT -- requirements
Module: qsfp_mgmt

Interface
REQ-001 SHALL have parameter PORTS, default 2, number of QSFP cages managed (1..8).
REQ-002 SHALL have parameter DEBOUNCE, default 1024, consecutive stable cycles for modprsl/intl.
REQ-003 SHALL have parameter RESET_CYCLES, default 2000, resetl low time per reset sequence.
REQ-004 SHALL have parameter INIT_CYCLES, default 4000, wait after resetl release before ready.
REQ-005 SHALL have parameter SEL_SETUP, default 4, cycles between modsell low and sel_gnt high.
REQ-006 SHALL use one clock and an asynchronous active-low reset: clock  in  1  block clock; resetn  in  1  async active-low reset.
REQ-007 SHALL have qsfp_modprsl  in  PORTS  module present, active low, asynchronous.
REQ-008 SHALL have qsfp_intl  in  PORTS  module interrupt, active low, asynchronous.
REQ-009 SHALL have qsfp_resetl / qsfp_lpmode / qsfp_modsell  out  PORTS each  cage reset (low=reset), low-power mode, I2C select (low=selected).
REQ-010 SHALL have soft_reset  in  PORTS  one-cycle request to rerun reset sequence.
REQ-011 SHALL have lpmode_req  in  PORTS  requested lpmode when port ready.
REQ-012 SHALL have sel_req  in  1, sel_port  in  max(1,$clog2(PORTS)), sel_gnt  out  1, sel_err  out  1  I2C select handshake.
REQ-013 SHALL have port_ready, port_int, present_chg  out  PORTS each  ready level, debounced interrupt level (high=asserted), one-cycle presence-change pulse.

Function
REQ-014 SHALL synchronise modprsl and intl through two flops per bit, then debounce: debounced value flips only after synced value differs for DEBOUNCE consecutive cycles; any agreement clears the counter.
REQ-015 SHALL make debounced value change exactly DEBOUNCE+2 clock edges after a stable pin change is first sampled.
REQ-016 SHALL pulse present_chg[i] for one cycle, the cycle after debounced presence of port i changes.
REQ-017 SHALL drive port_int[i] = inverted debounced intl[i], masked to 0 unless port i is READY.
REQ-018 SHALL run per-port FSM ABSENT -> RESET -> INIT -> READY.
REQ-019 ABSENT: resetl=0, lpmode=1; leaves to RESET when debounced present.
REQ-020 RESET: resetl=0, lpmode=1, counts RESET_CYCLES cycles then INIT.
REQ-021 INIT: resetl=1, lpmode=1, counts INIT_CYCLES cycles then READY.
REQ-022 READY: resetl=1, lpmode=lpmode_req[i], port_ready[i]=1.
REQ-023 Debounced removal SHALL force ABSENT next cycle from any state, counter cleared.
REQ-024 soft_reset[i] in RESET, INIT or READY SHALL enter RESET with counter reloaded; ignored in ABSENT; removal wins over simultaneous soft_reset.
REQ-025 SHALL run select FSM IDLE -> SETUP -> GRANT, plus ERR; at most one modsell bit low at any time.
REQ-026 IDLE: on sel_req=1 sample sel_port; if port < PORTS and READY, drive its modsell low and enter SETUP; else pulse sel_err one cycle and enter ERR.
REQ-027 SETUP: after SEL_SETUP cycles assert sel_gnt, enter GRANT; sel_port changes after sampling ignored.
REQ-028 GRANT: hold modsell low and sel_gnt=1 while sel_req=1; sel_req=0 deasserts both next cycle, returns IDLE.
REQ-029 Selected port leaving READY in SETUP or GRANT SHALL release modsell and sel_gnt next cycle, pulse sel_err, enter ERR.
REQ-030 sel_req=0 in SETUP SHALL release modsell and return IDLE without grant.
REQ-031 ERR: outputs idle; return IDLE when sel_req=0.

Reset
REQ-032 SHALL on resetn=0 asynchronously set resetl=0, lpmode=1, modsell=1 (all bits), sel_gnt=0, sel_err=0, port_ready=0, port_int=0, present_chg=0, all FSMs ABSENT/IDLE, debounced modprsl=1, debounced intl=1, counters 0.
REQ-033 SHALL treat modules present at reset release as new insertions (present_chg pulse, full sequence).

Verification (PORTS=2, DEBOUNCE=4, RESET_CYCLES=8, INIT_CYCLES=16, SEL_SETUP=2)
REQ-034 Insertion: modprsl[0] 1->0 -> present_chg[0] pulse 1 cycle after debounce, resetl[0] low 8 cycles, then high, port_ready[0]=1 after 16 more cycles.
REQ-035 Glitch: modprsl[1] low for 3 cycles -> no present_chg, port 1 stays ABSENT, resetl[1]=0.
REQ-036 Select: port 0 READY, sel_req=1 sel_port=0 -> modsell=2'b10, sel_gnt=1 two cycles later; sel_req=0 -> modsell=2'b11, sel_gnt=0 next cycle.
REQ-037 Select error: sel_port=1 with port 1 ABSENT -> sel_err one-cycle pulse, modsell stays 2'b11, no grant until sel_req toggles.
REQ-038 Removal in GRANT: port 0 removed -> port_ready[0]=0, modsell=2'b11, sel_gnt=0, sel_err pulse, resetl[0]=0.
REQ-039 soft_reset[0] in READY with lpmode_req[0]=0 -> lpmode[0]=1, resetl[0] low 8 cycles, ready again after 24 cycles; resetn low mid-sequence -> all outputs at REQ-032 values immediately.
